sisc_mem_arb: RTL and testbench

Multi-cycle arbiter that shares one single-ported unified memory between the SISC instruction-fetch path (driven by `ctrl`/`pc`) and the load/store path. It accepts one request per requester with a hold-until-done handshake and latches the winning transaction. It drives the memory for a fixed number of wait cycles, then returns read data with a one-cycle done pulse. It sits between `ctrl`/`ir`/`rf` and the memory, replacing the direct `pc`→`im` connection.

---
 rtl/sisc_mem_arb.sv | 166 ++++++++++++++++
 tb/tb_sisc_mem_arb.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_mem_arb.sv
// -----------------------------------------------------------------------------
// sisc_mem_arb
//
// Shares one single-ported unified memory between the SISC instruction-fetch
// path (if_*) and the load/store path (ls_*). One transaction is in flight at
// a time. The winner's address/we/wdata are latched straight into the mem_*
// output registers, the memory is driven for WAIT_CYC cycles, and the read
// word is returned together with a one-cycle done pulse.
//
// Handshake (both requesters): req is raised with addr/we/wdata valid and is
// held until the matching done pulse is seen; the requester drops req in the
// cycle after done. A req still high when the arbiter is back in IDLE is a
// new request. Inputs that change after the grant are ignored, and done still
// pulses if req was withdrawn early.
//
// Ports:
//   clk, rst_f             clock, asynchronous active-low reset
//   if_req/if_addr         fetch request and address
//   if_rdata/if_done       fetched word, one-cycle completion pulse
//   ls_req/ls_we/ls_addr/ls_wdata   load/store request (ls_we=1 is a store)
//   ls_rdata/ls_done       load data, one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   busy                   high while in ACCESS or DONE
//   dbg_state              current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Parameters: ADDR_W, DATA_W, WAIT_CYC (memory access cycles, 1..15).
//
// Build option: define SISC_MEM_ARB_RR_EN for round-robin arbitration;
// otherwise load/store has fixed priority over fetch.
// -----------------------------------------------------------------------------
module sisc_mem_arb #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // wcnt counts down to zero, so the last access cycle is the one seen
    // with wcnt == 0.
    localparam logic [3:0] WCNT_LOAD = 4'(WAIT_CYC - 1);

    logic [1:0] state;
    logic [3:0] wcnt;
    logic       owner;
    logic       any_req;
    logic       grant_ls;

    assign any_req   = if_req | ls_req;
    assign dbg_state = state;

`ifdef SISC_MEM_ARB_RR_EN
    // Records the last granted requester; on a collision the other one wins.
    logic last_owner;

    assign grant_ls = ls_req & (~if_req | (last_owner == OWN_IF));

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            last_owner <= OWN_IF;
        end else if ((state == ST_IDLE) && any_req) begin
            last_owner <= grant_ls;
        end
    end
`else
    assign grant_ls = ls_req;
`endif

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state     <= ST_IDLE;
            wcnt      <= 4'd0;
            owner     <= OWN_IF;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        // The mem_* registers double as the latched
                        // transaction, so later input changes cannot leak in.
                        state     <= ST_ACCESS;
                        busy      <= 1'b1;
                        owner     <= grant_ls;
                        wcnt      <= WCNT_LOAD;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_ls & ls_we;
                        mem_addr  <= grant_ls ? ls_addr : if_addr;
                        mem_wdata <= grant_ls ? ls_wdata : '0;
                    end
                end

                ST_ACCESS: begin
                    if (wcnt == 4'd0) begin
                        state  <= ST_DONE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner == OWN_LS) begin
                            ls_done <= 1'b1;
                            // A store leaves the load data register alone.
                            if (!mem_we) begin
                                ls_rdata <= mem_rdata;
                            end
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end

                ST_DONE: begin
                    // Requests are not looked at here; the requester has one
                    // cycle to drop req before IDLE samples it again.
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    if_done <= 1'b0;
                    ls_done <= 1'b0;
                end

                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    if_done <= 1'b0;
                    ls_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_sisc_mem_arb
//
// Self-checking bench for sisc_mem_arb with WAIT_CYC=2. A behavioural memory
// answers the DUT (valid read data only in the last access cycle), a monitor
// logs every access cycle and every done pulse, and a transaction-level model
// predicts the grant order, access cycles and returned data from the
// arbitration and timing rules.
// -----------------------------------------------------------------------------
module tb_sisc_mem_arb;

    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int WC     = 2;
    localparam int MEM_N  = 1024;
    localparam int DONE_W = 16 + 1 + DW;       // {cycle, owner, rdata}
    localparam int ACC_W  = 16 + AW + 1 + DW;  // {cycle, addr, we, wdata}
    localparam logic [DW-1:0] ZW = '0;

    // ---------------------------------------------------------- clock/reset
    logic clk   = 1'b0;
    logic rst_f = 1'b0;
    always #5 clk = ~clk;

    logic          if_req   = 1'b0;
    logic [AW-1:0] if_addr  = '0;
    logic          ls_req   = 1'b0;
    logic          ls_we    = 1'b0;
    logic [AW-1:0] ls_addr  = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_done, ls_done, mem_en, mem_we, busy;
    logic [1:0]    dbg_state;

    sisc_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) dut (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_done(ls_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int inv_viol = 0;
    int acc_run = 0;

    logic [DW-1:0]     dev_mem [MEM_N];
    logic [DW-1:0]     ref_mem [MEM_N];
    logic [DONE_W-1:0] exp_q[$];
    logic [DONE_W-1:0] done_q[$];
    logic [ACC_W-1:0]  exp_acc_q[$];
    logic [ACC_W-1:0]  acc_q[$];
    logic [DW-1:0]     exp_if_rdata, exp_ls_rdata;
    logic              m_last;

    // Initial memory image shared by the device and the model.
    function automatic logic [DW-1:0] seed_word(input int i);
        if (i == 16) return 32'h1234ABCD;
        return (32'(i) * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: writes on enabled write cycles, read data valid only
    // in the last access cycle and noise otherwise.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < MEM_N; i++) dev_mem[i] <= seed_word(i);
        end else if (mem_en && mem_we) begin
            dev_mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_en) begin
            mem_rdata <= (acc_run == WC - 1) ? dev_mem[mem_addr[9:0]] : $urandom;
            acc_run   <= acc_run + 1;
        end else begin
            mem_rdata <= $urandom;
            acc_run   <= 0;
        end
    end

    // Monitor: logs observed traffic, counts protocol invariant violations.
    always @(negedge clk) begin
        if (mem_en) acc_q.push_back({16'(cyc), mem_addr, mem_we, mem_we ? mem_wdata : ZW});
        if (if_done) done_q.push_back({16'(cyc), 1'b0, if_rdata});
        if (ls_done) done_q.push_back({16'(cyc), 1'b1, ls_rdata});
        if ((if_done && ls_done) || (mem_en && !busy) || (mem_en && (if_done || ls_done)))
            inv_viol <= inv_viol + 1;
    end

    // ------------------------------------------------------------ model
    // Requests presented before edge c0+1 are served one after another; the
    // k-th grant lands WC+2 cycles after the previous one, its accesses fill
    // WC cycles and done follows in the next cycle.
    task automatic model_batch(input int c0, input bit do_if, input bit do_ls, input bit we,
                               input logic [AW-1:0] a_if, input logic [AW-1:0] a_ls,
                               input logic [DW-1:0] wd);
        bit            ls_first, is_ls, st;
        int            k, g;
        logic [AW-1:0] a;
        logic [DW-1:0] rd;
        ls_first = do_ls;
`ifdef SISC_MEM_ARB_RR_EN
        if (do_if && do_ls) ls_first = (m_last == 1'b0);
`endif
        k = 0;
        for (int n = 0; n < 2; n++) begin
            is_ls = (n == 0) ? ls_first : !ls_first;
            if (is_ls ? !do_ls : !do_if) continue;
            g  = c0 + 1 + k * (WC + 2);
            a  = is_ls ? a_ls : a_if;
            st = is_ls && we;
            for (int i = 0; i < WC; i++) exp_acc_q.push_back({16'(g + i), a, st, st ? wd : ZW});
            if (st) begin
                ref_mem[a[9:0]] = wd;
                rd = exp_ls_rdata;
            end else begin
                rd = ref_mem[a[9:0]];
                if (is_ls) exp_ls_rdata = rd;
                else       exp_if_rdata = rd;
            end
            exp_q.push_back({16'(g + WC), is_ls, rd});
            m_last = is_ls;
            k++;
        end
    endtask

    task automatic model_reset();
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
        m_last       = 1'b0;
    endtask

    // ---------------------------------------------------------- drivers
    task automatic clear_q();
        exp_q.delete(); done_q.delete(); exp_acc_q.delete(); acc_q.delete();
    endtask

    // Called right after a negedge; the grant edge is c0+1.
    task automatic drive(input bit do_if, input bit do_ls, input bit we,
                         input logic [AW-1:0] a_if, input logic [AW-1:0] a_ls,
                         input logic [DW-1:0] wd, output int c0);
        if_req = do_if; if_addr = a_if;
        ls_req = do_ls; ls_we = we; ls_addr = a_ls; ls_wdata = wd;
        c0 = cyc;
    endtask

    // Each requester drops req in the cycle it sees its done pulse.
    task automatic serve(input int budget, output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (if_req || ls_req) begin
            @(negedge clk);
            n++;
            if (if_done) if_req = 1'b0;
            if (ls_done) ls_req = 1'b0;
            if (n >= budget) begin
                timed_out = 1'b1;
                if_req = 1'b0;
                ls_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        model_reset();
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = seed_word(i);
        rst_f = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_en, mem_we, if_done, ls_done, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_en, mem_we, if_done, ls_done, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if ({if_rdata, ls_rdata} !== '0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, ls_rdata);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        rst_f = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, mem_en} !== 2'b0) begin
            errors++; $display("FAIL idle_no_req: got %b want 00", {busy, mem_en});
        end
    endtask

    task automatic test_fetch();
        int c0; bit to;
        clear_q();
        drive(1'b1, 1'b0, 1'b0, 16'h0010, '0, '0, c0);
        model_batch(c0, 1'b1, 1'b0, 1'b0, 16'h0010, '0, '0);
        serve(20, to);
        checks++;
        if (to) begin errors++; $display("FAIL fetch_timeout: got timeout want done"); end
        checks++;
        if (acc_q.size() != 2) begin errors++; $display("FAIL fetch_acc_count: got %0d want 2", acc_q.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (acc_q[i] !== {16'(c0 + 1 + i), 16'h0010, 1'b0, ZW}) begin
                errors++; $display("FAIL fetch_acc[%0d]: got %h want %h", i, acc_q[i], {16'(c0 + 1 + i), 16'h0010, 1'b0, ZW});
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] !== {16'(c0 + 3), 1'b0, 32'h1234ABCD}) begin
            errors++; $display("FAIL fetch_done: got %0d/%h want 1/%h", done_q.size(), done_q[0], {16'(c0 + 3), 1'b0, 32'h1234ABCD});
        end
        checks++;
        if (if_rdata !== 32'h1234ABCD) begin errors++; $display("FAIL fetch_hold: got %h want 1234abcd", if_rdata); end
    endtask

    task automatic test_store();
        int c0; bit to;
        clear_q();
        drive(1'b0, 1'b1, 1'b1, '0, 16'h0200, 32'hDEADBEEF, c0);
        model_batch(c0, 1'b0, 1'b1, 1'b1, '0, 16'h0200, 32'hDEADBEEF);
        serve(20, to);
        checks++;
        if (to) begin errors++; $display("FAIL store_timeout: got timeout want done"); end
        checks++;
        if (acc_q.size() != 2) begin errors++; $display("FAIL store_acc_count: got %0d want 2", acc_q.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (acc_q[i] !== {16'(c0 + 1 + i), 16'h0200, 1'b1, 32'hDEADBEEF}) begin
                errors++; $display("FAIL store_acc[%0d]: got %h want %h", i, acc_q[i], {16'(c0 + 1 + i), 16'h0200, 1'b1, 32'hDEADBEEF});
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] !== {16'(c0 + 3), 1'b1, ZW}) begin
            errors++; $display("FAIL store_done: got %0d/%h want 1/%h", done_q.size(), done_q[0], {16'(c0 + 3), 1'b1, ZW});
        end
        checks++;
        if (ls_rdata !== ZW) begin errors++; $display("FAIL store_rdata: got %h want 0", ls_rdata); end
        checks++;
        if (dev_mem[512] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_written: got %h want deadbeef", dev_mem[512]); end
    endtask

    task automatic test_collision();
        int c0; bit to; logic [AW-1:0] a_if, a_ls; bit we; logic [DW-1:0] wd;
        for (int r = 0; r < 2; r++) begin
            clear_q();
            a_if = AW'($urandom); a_ls = AW'($urandom); we = 1'(r); wd = $urandom;
            drive(1'b1, 1'b1, we, a_if, a_ls, wd, c0);
            model_batch(c0, 1'b1, 1'b1, we, a_if, a_ls, wd);
            serve(40, to);
            checks++;
            if (to) begin errors++; $display("FAIL coll_timeout[%0d]: got timeout want done", r); end
            checks++;
            if (done_q.size() != exp_q.size()) begin
                errors++; $display("FAIL coll_done_count[%0d]: got %0d want %0d", r, done_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                checks++;
                if (done_q[i] !== exp_q[i]) begin errors++; $display("FAIL coll_done[%0d.%0d]: got %h want %h", r, i, done_q[i], exp_q[i]); end
            end
            checks++;
            if (acc_q.size() != exp_acc_q.size()) begin
                errors++; $display("FAIL coll_acc_count[%0d]: got %0d want %0d", r, acc_q.size(), exp_acc_q.size());
            end else foreach (exp_acc_q[i]) begin
                checks++;
                if (acc_q[i] !== exp_acc_q[i]) begin errors++; $display("FAIL coll_acc[%0d.%0d]: got %h want %h", r, i, acc_q[i], exp_acc_q[i]); end
            end
        end
    endtask

    task automatic test_addr_change();
        int c0; bit to;
        clear_q();
        drive(1'b1, 1'b0, 1'b0, 16'h0010, '0, '0, c0);
        model_batch(c0, 1'b1, 1'b0, 1'b0, 16'h0010, '0, '0);
        @(negedge clk);
        if_addr = 16'h0020;
        serve(20, to);
        checks++;
        if (to) begin errors++; $display("FAIL addr_chg_timeout: got timeout want done"); end
        checks++;
        if (acc_q.size() != exp_acc_q.size()) begin
            errors++; $display("FAIL addr_chg_acc_count: got %0d want %0d", acc_q.size(), exp_acc_q.size());
        end else foreach (exp_acc_q[i]) begin
            checks++;
            if (acc_q[i] !== exp_acc_q[i]) begin errors++; $display("FAIL addr_chg_acc[%0d]: got %h want %h", i, acc_q[i], exp_acc_q[i]); end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL addr_chg_done: got %0d/%h want 1/%h", done_q.size(), done_q[0], exp_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        int c0, r; bit to; logic [AW-1:0] a;
        clear_q();
        a = AW'($urandom);
        drive(1'b1, 1'b0, 1'b0, a, '0, '0, c0);
        @(negedge clk);                 // first access cycle
        #2 rst_f = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({mem_en, mem_we, if_done, ls_done, busy} !== 5'b0 || mem_addr !== '0 || if_rdata !== ZW) begin
            errors++; $display("FAIL rst_mid_outputs: got %b/%h/%h want 00000/0/0",
                               {mem_en, mem_we, if_done, ls_done, busy}, mem_addr, if_rdata);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d want 0", dbg_state); end
        @(negedge clk);
        checks++;
        if (done_q.size() != 0 || acc_q.size() != 1) begin
            errors++; $display("FAIL rst_mid_abort: got %0d dones/%0d accesses want 0/1", done_q.size(), acc_q.size());
        end
        clear_q();
        rst_f = 1'b1;
        r = cyc;
        model_batch(r, 1'b1, 1'b0, 1'b0, a, '0, '0);
        serve(20, to);
        checks++;
        if (to) begin errors++; $display("FAIL rst_mid_timeout: got timeout want done"); end
        checks++;
        if (acc_q.size() != exp_acc_q.size()) begin
            errors++; $display("FAIL rst_mid_acc_count: got %0d want %0d", acc_q.size(), exp_acc_q.size());
        end else foreach (exp_acc_q[i]) begin
            checks++;
            if (acc_q[i] !== exp_acc_q[i]) begin errors++; $display("FAIL rst_mid_acc[%0d]: got %h want %h", i, acc_q[i], exp_acc_q[i]); end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL rst_mid_done: got %0d/%h want 1/%h", done_q.size(), done_q[0], exp_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        int c0, n, guard; logic [AW-1:0] ba [3];
        clear_q();
        for (int k = 0; k < 3; k++) ba[k] = AW'($urandom);
        drive(1'b1, 1'b0, 1'b0, ba[0], '0, '0, c0);
        for (int k = 0; k < 3; k++) model_batch(c0 + k * (WC + 2), 1'b1, 1'b0, 1'b0, ba[k], '0, '0);
        n = 0; guard = 0;
        while (n < 3 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (if_done) begin
                n++;
                if (n == 3) if_req = 1'b0;
                else        if_addr = ba[n];
            end
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (n != 3) begin errors++; $display("FAIL b2b_timeout: got %0d dones want 3", n); end
        checks++;
        if (done_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_done_count: got %0d want %0d", done_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (done_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_done[%0d]: got %h want %h", i, done_q[i], exp_q[i]); end
        end
        checks++;
        if (acc_q.size() != exp_acc_q.size()) begin
            errors++; $display("FAIL b2b_acc_count: got %0d want %0d", acc_q.size(), exp_acc_q.size());
        end else foreach (exp_acc_q[i]) begin
            checks++;
            if (acc_q[i] !== exp_acc_q[i]) begin errors++; $display("FAIL b2b_acc[%0d]: got %h want %h", i, acc_q[i], exp_acc_q[i]); end
        end
    endtask

    task automatic test_random();
        int c0, mode; bit to, we; logic [AW-1:0] a_if, a_ls; logic [DW-1:0] wd;
        for (int it = 0; it < 24; it++) begin
            clear_q();
            mode = $urandom_range(1, 3);
            we   = 1'($urandom_range(0, 1));
            a_if = AW'($urandom); a_ls = AW'($urandom); wd = $urandom;
            // Occasionally hit a freshly written word from the other port.
            if ($urandom_range(0, 3) == 0) a_if = a_ls;
            drive(mode[0], mode[1], we, a_if, a_ls, wd, c0);
            model_batch(c0, mode[0], mode[1], we, a_if, a_ls, wd);
            serve(40, to);
            checks++;
            if (to) begin errors++; $display("FAIL rand_timeout[%0d]: got timeout want done", it); end
            checks++;
            if (done_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand_done_count[%0d]: got %0d want %0d", it, done_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                checks++;
                if (done_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_done[%0d.%0d]: got %h want %h", it, i, done_q[i], exp_q[i]); end
            end
            checks++;
            if (acc_q.size() != exp_acc_q.size()) begin
                errors++; $display("FAIL rand_acc_count[%0d]: got %0d want %0d", it, acc_q.size(), exp_acc_q.size());
            end else foreach (exp_acc_q[i]) begin
                checks++;
                if (acc_q[i] !== exp_acc_q[i]) begin errors++; $display("FAIL rand_acc[%0d.%0d]: got %h want %h", it, i, acc_q[i], exp_acc_q[i]); end
            end
            checks++;
            if (if_rdata !== exp_if_rdata || ls_rdata !== exp_ls_rdata) begin
                errors++; $display("FAIL rand_rdata_hold[%0d]: got %h/%h want %h/%h", it, if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (inv_viol !== 0) begin
            errors++; $display("FAIL invariants: got %0d violating cycles want 0", inv_viol);
        end
    endtask

    // ---------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_collision();
        test_addr_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
